// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store controller.
// Also holds the access legality check used at request acceptance.
package lsu_pkg;

  localparam int unsigned VEC_LINES    = 4;
  localparam int unsigned LINE_W       = 128;
  localparam int unsigned MEM_LINES    = 1024;
  localparam int unsigned SCALAR_LINES = 256;

  typedef logic [LINE_W-1:0] line_t;
  typedef line_t [VEC_LINES-1:0] vec_t;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_e;

  // Vectors need line alignment and all four lines in range, with no wrap.
  function automatic logic lsu_illegal(logic vector, logic [1:0] size, logic [31:0] addr);
    logic bad;
    if (vector) begin
      bad = (addr[3:0] != 4'h0) || (addr[31:4] > 28'(MEM_LINES - VEC_LINES));
    end else begin
      bad = (addr[31:4] >= 28'(SCALAR_LINES));
      case (size)
        2'b10:    bad = 1'b1;
        SizeHalf: bad = bad | addr[0];
        SizeWord: bad = bad | (addr[1:0] != 2'b00);
        default:  ;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response handshake plus data memory port of the load/store controller.
// slave is the controller's view; master is the core and memory side.
interface lsu_mem_ctrl_if;
  import lsu_pkg::*;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        req_vector_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  vec_t        req_vwdata_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_err_o;
  logic [31:0] rsp_rdata_o;
  vec_t        rsp_vrdata_o;

  logic        data_mem_req;
  logic        data_mem_wr;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_wr_data;
  logic [1:0]  data_mem_byte_en;
  logic        is_vector_o;
  vec_t        vec_data_wr_data_o;
  logic [31:0] mem_rd_data;
  vec_t        vec_mem_rd_data_i;

  modport slave (
    input  req_valid_i, req_store_i, req_size_i, req_unsigned_i, req_vector_i,
    input  req_addr_i, req_wdata_i, req_vwdata_i, rsp_ready_i,
    input  mem_rd_data, vec_mem_rd_data_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_vrdata_o,
    output data_mem_req, data_mem_wr, data_mem_addr, data_mem_wr_data,
    output data_mem_byte_en, is_vector_o, vec_data_wr_data_o
  );

  modport master (
    output req_valid_i, req_store_i, req_size_i, req_unsigned_i, req_vector_i,
    output req_addr_i, req_wdata_i, req_vwdata_i, rsp_ready_i,
    output mem_rd_data, vec_mem_rd_data_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_vrdata_o,
    input  data_mem_req, data_mem_wr, data_mem_addr, data_mem_wr_data,
    input  data_mem_byte_en, is_vector_o, vec_data_wr_data_o
  );

endinterface

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Scalar load extension: picks the low byte/half of the read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_unsigned & i_rd[7];
  assign w_sign_h = ~i_unsigned & i_rd[15];

  always_comb begin
    o_data = i_rd;
    case (i_size)
      SizeByte: o_data = {{24{w_sign_b}}, i_rd[7:0]};
      SizeHalf: o_data = {{16{w_sign_h}}, i_rd[15:0]};
      default:  o_data = i_rd;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one scalar or vector access at a time, issues a
// single-cycle memory request and returns extended load data, vector data or an ack.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  lsu_mem_ctrl_if.slave  bus
);

  lsu_state_e  r_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_vector;
  logic        r_err;
  logic [31:0] r_rdata;
  vec_t        r_vrdata;
  logic        r_mem_req;
  logic        r_mem_wr;
  logic        r_is_vec;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_mem_be;
  vec_t        r_vec_wdata;

  logic        w_illegal;
  logic [31:0] w_ext_data;

  assign w_illegal = lsu_illegal(bus.req_vector_i, bus.req_size_i, bus.req_addr_i);

  lsu_load_ext u_load_ext (
    .i_rd       (bus.mem_rd_data),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_vector    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_vrdata    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_is_vec    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 2'b00;
      r_vec_wdata <= '0;
    end else begin
      // Strobes are one-cycle pulses; only the accept edge raises them.
      r_mem_req <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_is_vec  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.req_valid_i) begin
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_vector   <= bus.req_vector_i;
            r_err      <= w_illegal;
            r_rdata    <= '0;
            if (w_illegal) begin
              r_state <= StResp;
            end else begin
              r_state     <= StIssue;
              r_mem_req   <= 1'b1;
              r_mem_wr    <= bus.req_store_i;
              r_is_vec    <= bus.req_vector_i;
              r_mem_addr  <= bus.req_addr_i;
              r_mem_wdata <= bus.req_wdata_i;
              r_mem_be    <= bus.req_size_i;
              r_vec_wdata <= bus.req_vwdata_i;
            end
          end
        end
        StIssue: r_state <= r_mem_wr ? StResp : StWait;
        StWait: begin
          if (r_vector) r_vrdata <= bus.vec_mem_rd_data_i;
          else          r_rdata  <= w_ext_data;
          r_state <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready_o        = (r_state == StIdle);
  assign bus.rsp_valid_o        = (r_state == StResp);
  assign bus.rsp_err_o          = r_err;
  assign bus.rsp_rdata_o        = r_rdata;
  assign bus.rsp_vrdata_o       = r_vrdata;
  assign bus.data_mem_req       = r_mem_req;
  assign bus.data_mem_wr        = r_mem_wr;
  assign bus.data_mem_addr      = r_mem_addr;
  assign bus.data_mem_wr_data   = r_mem_wdata;
  assign bus.data_mem_byte_en   = r_mem_be;
  assign bus.is_vector_o        = r_is_vec;
  assign bus.vec_data_wr_data_o = r_vec_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares them as the controller responds.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    logic        chk_vr;
    vec_t        vrdata;
    int          lat;
    int          nreq;
    int          nwr;
    int          nvec;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int a, int b, int c, int d);
    vec_t v;
    v[0] = line_t'(a);
    v[1] = line_t'(b);
    v[2] = line_t'(c);
    v[3] = line_t'(d);
    return v;
  endfunction

  // Memory model: scalar words keyed by byte address, vector lines by line index.
  logic [31:0] smem[int];
  line_t       vmem[int];
  always @(posedge clk) begin
    if (bus.data_mem_req) begin
      if (bus.is_vector_o) begin
        for (int i = 0; i < VEC_LINES; i++) begin
          if (bus.data_mem_wr) vmem[int'(bus.data_mem_addr[31:4]) + i] = bus.vec_data_wr_data_o[i];
          else bus.vec_mem_rd_data_i[i] <= vmem.exists(int'(bus.data_mem_addr[31:4]) + i) ?
                                           vmem[int'(bus.data_mem_addr[31:4]) + i] : '0;
        end
      end else if (bus.data_mem_wr) begin
        case (bus.data_mem_byte_en)
          2'b00:   smem[int'(bus.data_mem_addr)] = {24'h0, bus.data_mem_wr_data[7:0]};
          2'b01:   smem[int'(bus.data_mem_addr)] = {16'h0, bus.data_mem_wr_data[15:0]};
          default: smem[int'(bus.data_mem_addr)] = bus.data_mem_wr_data;
        endcase
      end else begin
        bus.mem_rd_data <= smem.exists(int'(bus.data_mem_addr)) ? smem[int'(bus.data_mem_addr)] : 32'h0;
      end
    end
  end

  // Monitor: counts memory pulses per transaction and checks each accepted response.
  int first_cyc = -1;
  int m_req = 0;
  int m_wr = 0;
  int m_vec = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      first_cyc = -1;
      m_req = 0;
      m_wr = 0;
      m_vec = 0;
    end else begin
      if (bus.data_mem_req) begin
        m_req++;
        if (bus.data_mem_wr) m_wr++;
        if (bus.is_vector_o) m_vec++;
      end
      if (bus.rsp_valid_o && first_cyc < 0) first_cyc = cyc;
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response");
        end else begin
          e = sb.pop_front();
          chk($sformatf("t%0d_err", e.id), 512'(bus.rsp_err_o), 512'(e.err));
          chk($sformatf("t%0d_rdata", e.id), 512'(bus.rsp_rdata_o), 512'(e.rdata));
          if (e.chk_vr) chk($sformatf("t%0d_vrdata", e.id), bus.rsp_vrdata_o, e.vrdata);
          chk($sformatf("t%0d_latency", e.id), 512'(first_cyc - e.acc), 512'(e.lat));
          chk($sformatf("t%0d_mem_req", e.id), 512'(m_req), 512'(e.nreq));
          chk($sformatf("t%0d_mem_wr", e.id), 512'(m_wr), 512'(e.nwr));
          chk($sformatf("t%0d_is_vector", e.id), 512'(m_vec), 512'(e.nvec));
        end
        first_cyc = -1;
        m_req = 0;
        m_wr = 0;
        m_vec = 0;
      end
    end
  end

  task automatic issue(int id, logic st, logic [1:0] sz, logic un, logic vec, logic [31:0] a,
                       logic [31:0] wd, vec_t vwd, logic push, logic err, logic [31:0] rd,
                       logic chkvr, vec_t vrd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL t%0d_accept_timeout: got req_ready_o=0 expected 1", id);
      return;
    end
    bus.req_valid_i    = 1'b1;
    bus.req_store_i    = st;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = un;
    bus.req_vector_i   = vec;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    bus.req_vwdata_i   = vwd;
    if (push) sb.push_back('{id: id, err: err, rdata: rd, chk_vr: chkvr, vrdata: vrd,
                             lat: err ? 1 : (st ? 2 : 3), nreq: err ? 0 : 1,
                             nwr: (st && !err) ? 1 : 0, nvec: (vec && !err) ? 1 : 0,
                             acc: cyc});
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    vec_t v1234;
    vec_t v5678;
    int n;
    z = '0;
    v1234 = mkv(1, 2, 3, 4);
    v5678 = mkv(5, 6, 7, 8);
    bus.req_valid_i = 1'b0;
    bus.req_store_i = 1'b0;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_vector_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.req_vwdata_i = '0;
    bus.rsp_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 512'(bus.rsp_valid_o), 512'(0));
    chk("rst_mem_req", 512'(bus.data_mem_req), 512'(0));
    chk("rst_rdata", 512'(bus.rsp_rdata_o), 512'(0));
    chk("rst_err", 512'(bus.rsp_err_o), 512'(0));
    #1 reset_n = 1'b1;
    #1 chk("rst_ready", 512'(bus.req_ready_o), 512'(1));

    // Scalar word, byte and half round trips
    issue(1, 1, 2'b11, 0, 0, 32'h24, 32'hDEADBEEF, z, 1, 0, 32'h0, 0, z);
    issue(2, 0, 2'b11, 0, 0, 32'h24, 32'h0, z, 1, 0, 32'hDEADBEEF, 0, z);
    issue(3, 1, 2'b00, 0, 0, 32'h10, 32'h12345680, z, 1, 0, 32'h0, 0, z);
    issue(4, 0, 2'b00, 0, 0, 32'h10, 32'h0, z, 1, 0, 32'hFFFFFF80, 0, z);
    issue(5, 0, 2'b00, 1, 0, 32'h10, 32'h0, z, 1, 0, 32'h00000080, 0, z);
    issue(6, 1, 2'b01, 0, 0, 32'h20, 32'hABCD8001, z, 1, 0, 32'h0, 0, z);
    issue(7, 0, 2'b01, 0, 0, 32'h20, 32'h0, z, 1, 0, 32'hFFFF8001, 0, z);
    issue(8, 0, 2'b01, 1, 0, 32'h20, 32'h0, z, 1, 0, 32'h00008001, 0, z);

    // Scalar errors: misaligned, out of range, illegal size
    issue(9, 0, 2'b11, 0, 0, 32'h22, 32'h0, z, 1, 1, 32'h0, 0, z);
    issue(10, 0, 2'b01, 0, 0, 32'h13, 32'h0, z, 1, 1, 32'h0, 0, z);
    issue(11, 0, 2'b11, 0, 0, 32'h1000, 32'h0, z, 1, 1, 32'h0, 0, z);
    issue(12, 0, 2'b10, 0, 0, 32'h0, 32'h0, z, 1, 1, 32'h0, 0, z);

    // Vector accesses, including the last legal vector and the error cases
    issue(13, 1, 2'b00, 0, 1, 32'h100, 32'h0, v1234, 1, 0, 32'h0, 0, z);
    issue(14, 0, 2'b00, 0, 1, 32'h100, 32'h0, z, 1, 0, 32'h0, 1, v1234);
    issue(15, 1, 2'b00, 0, 1, 32'h3FC0, 32'h0, v5678, 1, 0, 32'h0, 0, z);
    issue(16, 0, 2'b00, 0, 1, 32'h3FC0, 32'h0, z, 1, 0, 32'h0, 1, v5678);
    issue(17, 0, 2'b00, 0, 1, 32'h3FD0, 32'h0, z, 1, 1, 32'h0, 1, v5678);
    issue(18, 0, 2'b00, 0, 1, 32'h108, 32'h0, z, 1, 1, 32'h0, 1, v5678);
    drain();

    // Response backpressure
    #1 bus.rsp_ready_i = 1'b0;
    issue(19, 0, 2'b11, 0, 0, 32'h24, 32'h0, z, 1, 0, 32'hDEADBEEF, 0, z);
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 512'(bus.rsp_valid_o), 512'(1));
      chk("bp_rdata", 512'(bus.rsp_rdata_o), 512'(32'hDEADBEEF));
      chk("bp_ready", 512'(bus.req_ready_o), 512'(0));
    end
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b1;
    drain();

    // Reset during WAIT abandons the load
    issue(0, 0, 2'b11, 0, 0, 32'h24, 32'h0, z, 0, 0, 32'h0, 0, z);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("wrst_rsp_valid", 512'(bus.rsp_valid_o), 512'(0));
    chk("wrst_mem_req", 512'(bus.data_mem_req), 512'(0));
    chk("wrst_mem_wr", 512'(bus.data_mem_wr), 512'(0));
    chk("wrst_is_vector", 512'(bus.is_vector_o), 512'(0));
    chk("wrst_err", 512'(bus.rsp_err_o), 512'(0));
    chk("wrst_rdata", 512'(bus.rsp_rdata_o), 512'(0));
    chk("wrst_addr", 512'(bus.data_mem_addr), 512'(0));
    chk("wrst_vrdata", bus.rsp_vrdata_o, 512'(0));
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 chk("wrst_ready", 512'(bus.req_ready_o), 512'(1));
    repeat (8) begin
      @(negedge clk);
      chk("wrst_no_rsp", 512'(bus.rsp_valid_o), 512'(0));
    end

    issue(20, 0, 2'b11, 0, 0, 32'h24, 32'h0, z, 1, 0, 32'hDEADBEEF, 1, z);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
